// File: rtl/add_result_buffer_if.sv
// Handshake and status bundle between an adder result producer, the result
// buffer and its downstream consumer.
interface add_result_buffer_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       sum_i;
    logic              carry_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       out_sum_o;
    logic              out_carry_o;
    logic [CW-1:0]     count_o;
    logic [CNT_W-1:0]  carry_cnt_o;

    modport slave (
        input  in_valid_i, sum_i, carry_i, out_ready_i,
        output in_ready_o, out_valid_o, out_sum_o, out_carry_o, count_o, carry_cnt_o
    );

    modport master (
        output in_valid_i, sum_i, carry_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_sum_o, out_carry_o, count_o, carry_cnt_o
    );
endinterface

// File: rtl/add_result_buffer.sv
// First-word-fall-through FIFO of {carry, sum} adder results with a
// saturating counter of accepted results that carried out.
module add_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    add_result_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [32:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;
    logic [CNT_W-1:0]  r_carry_cnt;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_push;
    logic              w_pop;
    logic [32:0]       w_head;

    // Ready/valid come from the registered count only, so no input reaches an output.
    assign w_in_ready  = (r_count != FULL_CNT);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid_i && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready_i;
    assign w_head      = r_mem[r_rptr];

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_sum_o   = w_out_valid ? w_head[31:0] : 32'h0;
    assign bus.out_carry_o = w_out_valid ? w_head[32]   : 1'b0;
    assign bus.count_o     = r_count;
    assign bus.carry_cnt_o = r_carry_cnt;

    // Storage is left uncleared; stale words are hidden by the empty-gating above.
    always_ff @(posedge clk_i) begin
        if (w_push && !clr_i) begin
            r_mem[r_wptr] <= {bus.carry_i, bus.sum_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_carry_cnt <= '0;
        end else if (clr_i) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_carry_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && bus.carry_i && (r_carry_cnt != '1)) begin
                r_carry_cnt <= r_carry_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_add_result_buffer.sv
// Directed and randomized bench for add_result_buffer with a queue-based model.
module tb_add_result_buffer;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    logic clr_i  = 1'b0;

    add_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    add_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [32:0] q[$];
    int          cnt_m  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] es;
        logic        ec;
        es = 32'h0;
        ec = 1'b0;
        if (q.size() != 0) begin
            es = q[0][31:0];
            ec = q[0][32];
        end
        check({tag, ".count"},     64'(bus.count_o),     64'(q.size()));
        check({tag, ".out_valid"}, 64'(bus.out_valid_o), 64'(q.size() != 0));
        check({tag, ".in_ready"},  64'(bus.in_ready_o),  64'(q.size() != DEPTH));
        check({tag, ".out_sum"},   64'(bus.out_sum_o),   64'(es));
        check({tag, ".out_carry"}, 64'(bus.out_carry_o), 64'(ec));
        check({tag, ".carry_cnt"}, 64'(bus.carry_cnt_o), 64'(cnt_m));
    endtask

    task automatic drive(input bit v, input logic [31:0] s, input bit c, input bit r);
        bus.in_valid_i  = v;
        bus.sum_i       = s;
        bus.carry_i     = c;
        bus.out_ready_i = r;
    endtask

    // One clock: model the FIFO rules from the inputs presented at the edge, then compare.
    task automatic cycle(input string tag);
        bit          acc, pp, clr, c;
        logic [31:0] s;
        acc = bus.in_valid_i && (q.size() < DEPTH);
        pp  = (q.size() > 0) && bus.out_ready_i;
        clr = clr_i;
        s   = bus.sum_i;
        c   = bus.carry_i;
        @(posedge clk);
        if (clr) begin
            q.delete();
            cnt_m = 0;
        end else begin
            if (pp) void'(q.pop_front());
            if (acc) begin
                q.push_back({c, s});
                if (c) cnt_m = (cnt_m < CNT_MAX) ? cnt_m + 1 : CNT_MAX;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // First edge after release accepts a push
        rst_ni = 1'b1;
        drive(1'b1, 32'h0000_0005, 1'b0, 1'b1);
        cycle("push5");
        check("push5_sum", 64'(bus.out_sum_o), 64'h5);
        check("push5_count", 64'(bus.count_o), 64'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cycle("pop5");
        check("pop5_count", 64'(bus.count_o), 64'd0);

        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b0, 1'b0);
            cycle("fill");
        end
        check("full_ready", 64'(bus.in_ready_o), 64'd0);
        check("full_count", 64'(bus.count_o), 64'd4);
        drive(1'b1, 32'hFF, 1'b0, 1'b0);
        cycle("reject");
        check("reject_count", 64'(bus.count_o), 64'd4);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", 64'(bus.out_sum_o), 64'(i));
            cycle("drain");
        end

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
            cycle("fill2");
        end
        drive(1'b1, 32'h20, 1'b0, 1'b1);
        cycle("full_pop");
        check("full_pop_count", 64'(bus.count_o), 64'd3);
        drive(1'b1, 32'h21, 1'b0, 1'b1);
        cycle("pushpop");
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        cycle("refill");
        check("refill_count", 64'(bus.count_o), 64'd4);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (4) cycle("drain2");

        drive(1'b1, 32'h1, 1'b1, 1'b0);
        cycle("carry1");
        drive(1'b1, 32'h2, 1'b0, 1'b0);
        cycle("carry0");
        drive(1'b1, 32'h3, 1'b1, 1'b0);
        cycle("carry1b");
        check("carry_cnt2", 64'(bus.carry_cnt_o), 64'd2);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cycle("to_two");
        clr_i = 1'b1;
        drive(1'b1, 32'h9, 1'b1, 1'b1);
        cycle("clear");
        clr_i = 1'b0;
        check("clear_count", 64'(bus.count_o), 64'd0);
        check("clear_valid", 64'(bus.out_valid_o), 64'd0);
        check("clear_ccnt", 64'(bus.carry_cnt_o), 64'd0);

        for (int i = 0; i < CNT_MAX + 5; i++) begin
            drive(1'b1, 32'(i), 1'b1, 1'b1);
            cycle("sat");
        end
        check("sat_value", 64'(bus.carry_cnt_o), 64'(CNT_MAX));
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        cycle("sat_drain");

        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            cycle("rand");
            if (i == 30) begin
                rst_ni = 1'b0;
                #1;
                q.delete();
                cnt_m = 0;
                check_all("async_rst");
                check("async_rst_valid", 64'(bus.out_valid_o), 64'd0);
                #1;
                rst_ni = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
